ttt_env_step: RTL
=================

Name: ttt_env_step

Overview:
- Tic-tac-toe environment/episode sequencer directly upstream of the Q-learning accelerator.
- Accepts the agent's chosen action, applies it to the board, plays the opponent move, and detects win/draw/loss.
- Presents {action, state, next_state, reward} to the accelerator, held stable for its fixed update latency.

Parameters:
- R_WIN, 8'd64: reward when the agent completes a line.
- R_DRAW, 8'd16: reward when the board fills with no line.
- R_LOSS, 8'd0: reward when the opponent completes a line.
- R_STEP, 8'd4: reward for a legal non-terminal move.
- R_ILLEGAL, 8'd0: reward for an occupied or out-of-range action.
- UPD_HOLD, 3: cycles the update outputs stay stable after upd_valid before the next action is accepted; legal range 1..15.
- LFSR_SEED, 16'hACE1: opponent LFSR reset value; must be nonzero.

Ports:
- clock, in, 1: system clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- start, in, 1: pulse; clears the board and begins an episode (honoured in IDLE or DONE only).
- act_valid, in, 1: act_in is valid.
- act_ready, out, 1: block can accept an action.
- act_in, in, 4: agent action; codes 1..9 select cells 0..8.
- action, out, 4: registered action for the Q update.
- state, out, 18: board before the move, 2 bits per cell; cell i at [2i+1:2i]; 00 empty, 01 agent, 10 opponent.
- next_state, out, 18: board after agent and opponent moves.
- reward, out, 8: reward for this step.
- upd_valid, out, 1: one-cycle strobe; update outputs are valid.
- done, out, 1: episode ended; high in DONE.
- result, out, 2: 00 none, 01 win, 10 loss, 11 draw; valid while done.

Behaviour:
- Reset: all outputs 0, board 0, FSM in IDLE, LFSR = LFSR_SEED.
- Handshake: an action transfers when act_valid & act_ready on a clock edge. act_ready is high only in WAIT_ACT.
- FSM states: IDLE, WAIT_ACT, APPLY, OPP_SCAN, ISSUE, HOLD, DONE.
  - IDLE/DONE + start: board := 0, result := 00, done := 0 -> WAIT_ACT.
  - WAIT_ACT + transfer: state := board; action := act_in -> APPLY.
  - APPLY:
    - act_in outside 1..9, or target cell nonzero: next_state := board, reward := R_ILLEGAL, episode continues -> ISSUE.
    - Otherwise write 01 into the cell.
    - If the agent has a line: reward := R_WIN, result := 01.
    - Else if the board is full: reward := R_DRAW, result := 11.
    - Either terminal case -> ISSUE with terminal flag set; else -> OPP_SCAN.
  - OPP_SCAN:
    - Scan pointer starts at start_idx and advances one cell per cycle, wrapping 8->0.
    - The first empty cell found gets 10.
    - If the opponent has a line: reward := R_LOSS, result := 10, terminal.
    - Else if the board is full: reward := R_DRAW, result := 11, terminal.
    - Else reward := R_STEP.
    - Worst case 9 cycles. Next state ISSUE.
  - ISSUE: next_state := board; upd_valid = 1 for exactly one cycle -> HOLD.
  - HOLD: counts UPD_HOLD cycles; action/state/next_state/reward held constant -> DONE if terminal, else WAIT_ACT.
- Line detection is combinational over 8 lines (3 rows, 3 columns, 2 diagonals) for the given player code.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clock.
- Latency from action transfer to upd_valid: 2 cycles on terminal or illegal paths; 3..11 cycles on the opponent path.
- Boundary rules:
  - start outside IDLE/DONE: ignored.
  - act_valid outside WAIT_ACT: ignored, and act_in is not sampled.
  - reset_n low mid-episode: immediate return to the reset values; any in-flight upd_valid is suppressed.
  - result and done stay stable until the next start.

Optional Feature:
- Macro TTT_OPP_RANDOM_EN.
- Defined: start_idx = LFSR[15:0] mod 9, sampled on entry to OPP_SCAN.
- Undefined: start_idx = 0, so the opponent always takes the lowest-index empty cell; the LFSR is not instantiated. This deterministic mode is what the test plan uses.

Test Plan:
1. Reset, start, act_in=5 -> 3 cycles after transfer: upd_valid=1, state=0, next_state=18'h00102 (cell4=01, cell0=10), reward=4, action=5.
2. Agent plays 1,4,7 while the opponent takes cells 1,2 -> third step: reward=64, result=01, done=1, next_state has no new 10 cell.
3. Action into an occupied cell -> upd_valid 2 cycles after transfer, next_state==state, reward=0, episode not done.
4. act_in=0 and act_in=12 -> treated as illegal, reward=0, board unchanged.
5. Opponent completes cells 0,1,2 -> reward=0, result=10, done=1; act_ready stays 0 until the next start.
6. Assert reset_n low during OPP_SCAN -> all outputs 0 asynchronously, no upd_valid; after release, start works normally.

Source files
------------

// File: rtl/ttt_env_step.sv
// ttt_env_step: tic-tac-toe episode sequencer feeding a Q-learning update engine.
// It accepts an agent action, applies it, lets the opponent reply, classifies the
// outcome and presents {action, state, next_state, reward} for a fixed hold window.
// Optional macro TTT_OPP_RANDOM_EN: the opponent scan starts at an LFSR-chosen cell.
// Without it, the opponent always takes the lowest-index empty cell and no LFSR exists.
module ttt_env_step #(
   parameter logic [7:0] R_WIN     = 8'd64,
   parameter logic [7:0] R_DRAW    = 8'd16,
   parameter logic [7:0] R_LOSS    = 8'd0,
   parameter logic [7:0] R_STEP    = 8'd4,
   parameter logic [7:0] R_ILLEGAL = 8'd0,
   parameter int         UPD_HOLD  = 3
`ifdef TTT_OPP_RANDOM_EN
   ,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_start,
   input  logic        i_act_valid,
   output logic        o_act_ready,
   input  logic [3:0]  i_act_in,
   output logic [3:0]  o_action,
   output logic [17:0] o_state,
   output logic [17:0] o_next_state,
   output logic [7:0]  o_reward,
   output logic        o_upd_valid,
   output logic        o_done,
   output logic [1:0]  o_result
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_ACT = 3'd1,
      S_APPLY    = 3'd2,
      S_OPP_SCAN = 3'd3,
      S_ISSUE    = 3'd4,
      S_HOLD     = 3'd5,
      S_DONE     = 3'd6
   } fsm_t;

   localparam logic [3:0] C_HOLD_LAST = 4'(UPD_HOLD);

   fsm_t        r_fsm, w_fsm_next;
   logic [17:0] r_board, w_board_next;
   logic [3:0]  r_action, w_action_next;
   logic [17:0] r_state, w_state_next;
   logic [17:0] r_next_state, w_next_state_next;
   logic [7:0]  r_reward, w_reward_next;
   logic        r_upd_valid, w_upd_valid_next;
   logic        r_done, w_done_next;
   logic        r_terminal, w_terminal_next;
   logic [1:0]  r_result, w_result_next;
   logic [3:0]  r_scan_ptr, w_scan_ptr_next;
   logic [3:0]  r_hold_cnt, w_hold_cnt_next;
   logic [3:0]  w_start_idx;

   logic [8:0]  w_empty;
   logic [8:0]  w_agent_hit;
   logic [8:0]  w_opp_hit;
   logic [17:0] w_board_agent;
   logic [17:0] w_board_opp;
   logic        w_act_ok;
   logic        w_agent_line, w_agent_full;
   logic        w_opp_line, w_opp_full;

   // True when player code p owns any of the 8 winning lines of board b.
   function automatic logic f_line(input logic [17:0] b, input logic [1:0] p);
      logic [8:0] m;
      for (int i = 0; i < 9; i++) begin
         m[i] = (b[2*i +: 2] == p);
      end
      return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
             (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
             (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   // True when no cell of board b is empty.
   function automatic logic f_full(input logic [17:0] b);
      logic f;
      f = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (b[2*i +: 2] == 2'b00) f = 1'b0;
      end
      return f;
   endfunction

   // Per-cell decode: a hit vector never matches for action codes 0 or 10..15,
   // so range checking and occupancy checking collapse into one OR-reduction.
   generate
      for (genvar gi = 0; gi < 9; gi++) begin : g_cell
         assign w_empty[gi]             = (r_board[2*gi +: 2] == 2'b00);
         assign w_agent_hit[gi]         = (r_action == 4'(gi + 1)) & w_empty[gi];
         assign w_opp_hit[gi]           = (r_scan_ptr == 4'(gi)) & w_empty[gi];
         assign w_board_agent[2*gi +: 2] = w_agent_hit[gi] ? 2'b01 : r_board[2*gi +: 2];
         assign w_board_opp[2*gi +: 2]   = w_opp_hit[gi]   ? 2'b10 : r_board[2*gi +: 2];
      end
   endgenerate

   assign w_act_ok     = |w_agent_hit;
   assign w_agent_line = f_line(w_board_agent, 2'b01);
   assign w_agent_full = f_full(w_board_agent);
   assign w_opp_line   = f_line(w_board_opp, 2'b10);
   assign w_opp_full   = f_full(w_board_opp);

`ifdef TTT_OPP_RANDOM_EN
   logic [15:0] r_lfsr;

   // Free-running Fibonacci LFSR (taps 16,14,13,11) that randomises the opponent scan start.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   assign w_start_idx = 4'(r_lfsr % 16'd9);
`else
   assign w_start_idx = 4'd0;
`endif

   // Next-state and datapath update decisions for the episode sequencer.
   always_comb begin
      w_fsm_next        = r_fsm;
      w_board_next      = r_board;
      w_action_next     = r_action;
      w_state_next      = r_state;
      w_next_state_next = r_next_state;
      w_reward_next     = r_reward;
      w_upd_valid_next  = 1'b0;
      w_done_next       = r_done;
      w_terminal_next   = r_terminal;
      w_result_next     = r_result;
      w_scan_ptr_next   = r_scan_ptr;
      w_hold_cnt_next   = r_hold_cnt;
      case (r_fsm)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_board_next    = 18'd0;
               w_result_next   = 2'b00;
               w_done_next     = 1'b0;
               w_terminal_next = 1'b0;
               w_fsm_next      = S_WAIT_ACT;
            end
         end
         S_WAIT_ACT: begin
            if (i_act_valid) begin
               w_state_next  = r_board;
               w_action_next = i_act_in;
               w_fsm_next    = S_APPLY;
            end
         end
         S_APPLY: begin
            w_fsm_next      = S_ISSUE;
            w_terminal_next = 1'b0;
            if (!w_act_ok) begin
               w_reward_next = R_ILLEGAL;
            end else begin
               w_board_next = w_board_agent;
               if (w_agent_line) begin
                  w_reward_next   = R_WIN;
                  w_result_next   = 2'b01;
                  w_terminal_next = 1'b1;
               end else if (w_agent_full) begin
                  w_reward_next   = R_DRAW;
                  w_result_next   = 2'b11;
                  w_terminal_next = 1'b1;
               end else begin
                  w_fsm_next      = S_OPP_SCAN;
                  w_scan_ptr_next = w_start_idx;
               end
            end
         end
         S_OPP_SCAN: begin
            if (|w_opp_hit) begin
               w_board_next = w_board_opp;
               w_fsm_next   = S_ISSUE;
               if (w_opp_line) begin
                  w_reward_next   = R_LOSS;
                  w_result_next   = 2'b10;
                  w_terminal_next = 1'b1;
               end else if (w_opp_full) begin
                  w_reward_next   = R_DRAW;
                  w_result_next   = 2'b11;
                  w_terminal_next = 1'b1;
               end else begin
                  w_reward_next = R_STEP;
               end
            end else begin
               w_scan_ptr_next = (r_scan_ptr == 4'd8) ? 4'd0 : r_scan_ptr + 4'd1;
            end
         end
         S_ISSUE: begin
            w_next_state_next = r_board;
            w_upd_valid_next  = 1'b1;
            w_hold_cnt_next   = 4'd0;
            w_fsm_next        = S_HOLD;
         end
         S_HOLD: begin
            if (r_hold_cnt == C_HOLD_LAST) begin
               w_done_next = r_terminal;
               if (r_terminal) w_fsm_next = S_DONE;
               else            w_fsm_next = S_WAIT_ACT;
            end else begin
               w_hold_cnt_next = r_hold_cnt + 4'd1;
            end
         end
         default: begin
            w_fsm_next = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_fsm <= S_IDLE;
      else            r_fsm <= w_fsm_next;
   end

   // Board, update-output and bookkeeping registers; reset drops any pending strobe.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_board      <= 18'd0;
         r_action     <= 4'd0;
         r_state      <= 18'd0;
         r_next_state <= 18'd0;
         r_reward     <= 8'd0;
         r_upd_valid  <= 1'b0;
         r_done       <= 1'b0;
         r_terminal   <= 1'b0;
         r_result     <= 2'b00;
         r_scan_ptr   <= 4'd0;
         r_hold_cnt   <= 4'd0;
      end else begin
         r_board      <= w_board_next;
         r_action     <= w_action_next;
         r_state      <= w_state_next;
         r_next_state <= w_next_state_next;
         r_reward     <= w_reward_next;
         r_upd_valid  <= w_upd_valid_next;
         r_done       <= w_done_next;
         r_terminal   <= w_terminal_next;
         r_result     <= w_result_next;
         r_scan_ptr   <= w_scan_ptr_next;
         r_hold_cnt   <= w_hold_cnt_next;
      end
   end

   assign o_act_ready  = (r_fsm == S_WAIT_ACT);
   assign o_action     = r_action;
   assign o_state      = r_state;
   assign o_next_state = r_next_state;
   assign o_reward     = r_reward;
   assign o_upd_valid  = r_upd_valid;
   assign o_done       = r_done;
   assign o_result     = r_result;

endmodule
